// File: rtl/ucc_counter_reg8.sv
// Registered universal counter/register: hold, load, count up, count down, chainable via cin/cout.
// Define UCC_SATURATE_EN to make the stage saturate at its limits instead of wrapping.
module ucc_counter_reg8 #(
   parameter int unsigned         WIDTH       = 8,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cin,
   input  logic [WIDTH-1:0] pin,
   input  logic [1:0]       min,
   output logic [WIDTH-1:0] fout,
   output logic             cout,
   output logic [1:0]       mout,
   output logic             tc
);

   localparam logic [1:0] ModeHold = 2'b00;
   localparam logic [1:0] ModeLoad = 2'b01;
   localparam logic [1:0] ModeUp   = 2'b10;
   localparam logic [1:0] ModeDown = 2'b11;

   logic [WIDTH-1:0] fout_q, fout_d;
   logic             tc_q, tc_d;
   logic             is_max, is_zero;
   logic             step_up, step_down;
   logic             at_limit;

   assign is_max    = &fout_q;
   assign is_zero   = ~|fout_q;
   assign step_up   = cin && (min == ModeUp);
   assign step_down = cin && (min == ModeDown);
   // A step that would cross the all-ones/zero boundary.
   assign at_limit  = (step_up && is_max) || (step_down && is_zero);

   always_comb begin
      fout_d = fout_q;
      tc_d   = 1'b0;
      unique case (min)
         ModeHold: fout_d = fout_q;
         ModeLoad: fout_d = pin;
         ModeUp: begin
            if (cin) begin
`ifdef UCC_SATURATE_EN
               if (!is_max) fout_d = fout_q + WIDTH'(1);
`else
               fout_d = fout_q + WIDTH'(1);
`endif
            end
         end
         ModeDown: begin
            if (cin) begin
`ifdef UCC_SATURATE_EN
               if (!is_zero) fout_d = fout_q - WIDTH'(1);
`else
               fout_d = fout_q - WIDTH'(1);
`endif
            end
         end
      endcase
      if (at_limit) tc_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fout_q <= RESET_VALUE;
         tc_q   <= 1'b0;
      end else begin
         fout_q <= fout_d;
         tc_q   <= tc_d;
      end
   end

`ifdef UCC_SATURATE_EN
   assign cout = 1'b0;
`else
   assign cout = at_limit;
`endif
   assign mout = min;
   assign fout = fout_q;
   assign tc   = tc_q;

endmodule

// File: tb/tb_ucc_counter_reg8.sv
// Bench for ucc_counter_reg8: vector table, chained 16-bit corner cases, randomized model check.
// Honours UCC_SATURATE_EN to select wrapping or saturating expectations.
module tb_ucc_counter_reg8;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cin;
   logic [7:0] pin;
   logic [1:0] min;
   logic [7:0] fout;
   logic       cout;
   logic [1:0] mout;
   logic       tc;

   // Chained pair forming a 16-bit counter.
   logic        c_rstn, c_cin;
   logic [1:0]  c_min;
   logic [15:0] c_pin;
   logic [7:0]  lo_fout, hi_fout;
   logic        lo_cout, hi_cout, lo_tc, hi_tc;
   logic [1:0]  lo_mout, hi_mout;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   ucc_counter_reg8 #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
      .clk(clk), .rstn(rstn), .cin(cin), .pin(pin), .min(min),
      .fout(fout), .cout(cout), .mout(mout), .tc(tc)
   );

   ucc_counter_reg8 #(.WIDTH(8), .RESET_VALUE(8'h00)) u_lo (
      .clk(clk), .rstn(c_rstn), .cin(c_cin), .pin(c_pin[7:0]), .min(c_min),
      .fout(lo_fout), .cout(lo_cout), .mout(lo_mout), .tc(lo_tc)
   );

   ucc_counter_reg8 #(.WIDTH(8), .RESET_VALUE(8'h00)) u_hi (
      .clk(clk), .rstn(c_rstn), .cin(lo_cout), .pin(c_pin[15:8]), .min(lo_mout),
      .fout(hi_fout), .cout(hi_cout), .mout(hi_mout), .tc(hi_tc)
   );

   typedef struct {
      logic       rstn;
      logic [1:0] min;
      logic       cin;
      logic [7:0] pin;
      logic       exp_cout;   // checked before the edge
      logic [7:0] exp_fout;   // checked after the edge
      logic       exp_tc;
   } vec_t;

   localparam int NVec = 19;
   vec_t tbl [NVec];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference state.
   int m_val;
   bit m_tc;
   bit saturate;

   initial begin
`ifdef UCC_SATURATE_EN
      saturate = 1'b1;
`else
      saturate = 1'b0;
`endif
      //           rstn  min    cin   pin    cout  fout   tc
      tbl[0]  = '{1'b0, 2'b10, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 2'b10, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0};
      tbl[2]  = '{1'b1, 2'b01, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
      tbl[3]  = '{1'b1, 2'b00, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0};
      tbl[4]  = '{1'b1, 2'b00, 1'b0, 8'h3C, 1'b0, 8'hA5, 1'b0};
      tbl[5]  = '{1'b1, 2'b00, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0};
      tbl[6]  = '{1'b1, 2'b01, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0};
      tbl[7]  = '{1'b1, 2'b10, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0};
`ifdef UCC_SATURATE_EN
      tbl[8]  = '{1'b1, 2'b10, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b1};
      tbl[9]  = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
`else
      tbl[8]  = '{1'b1, 2'b10, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
      tbl[9]  = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
`endif
      tbl[10] = '{1'b1, 2'b01, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
      tbl[11] = '{1'b1, 2'b11, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
`ifdef UCC_SATURATE_EN
      tbl[12] = '{1'b1, 2'b11, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
      tbl[13] = '{1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
`else
      tbl[12] = '{1'b1, 2'b11, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1};
      tbl[13] = '{1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
`endif
      tbl[14] = '{1'b1, 2'b01, 1'b0, 8'h7B, 1'b0, 8'h7B, 1'b0};
      tbl[15] = '{1'b1, 2'b10, 1'b1, 8'h00, 1'b0, 8'h7C, 1'b0};
      tbl[16] = '{1'b0, 2'b10, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[17] = '{1'b1, 2'b01, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0};
      tbl[18] = '{1'b1, 2'b01, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

      // Establish a known state before the table runs.
      rstn = 1'b0; cin = 1'b0; pin = 8'h00; min = 2'b00;
      c_rstn = 1'b0; c_cin = 1'b0; c_pin = 16'h0000; c_min = 2'b00;
      edge_settle();

      for (int i = 0; i < NVec; i++) begin
         rstn = tbl[i].rstn; min = tbl[i].min; cin = tbl[i].cin; pin = tbl[i].pin;
         #1;
         chk($sformatf("v%0d cout", i), {15'd0, cout}, {15'd0, tbl[i].exp_cout});
         chk($sformatf("v%0d mout", i), {14'd0, mout}, {14'd0, tbl[i].min});
         edge_settle();
         chk($sformatf("v%0d fout", i), {8'd0, fout}, {8'd0, tbl[i].exp_fout});
         chk($sformatf("v%0d tc", i), {15'd0, tc}, {15'd0, tbl[i].exp_tc});
      end

`ifndef UCC_SATURATE_EN
      // Chained carry: 0x00FF up -> 0x0100, then down -> 0x00FF.
      c_rstn = 1'b1; c_min = 2'b01; c_cin = 1'b0; c_pin = 16'h00FF;
      edge_settle();
      chk("chain load", {hi_fout, lo_fout}, 16'h00FF);
      c_min = 2'b10; c_cin = 1'b1;
      #1;
      chk("chain lo cout up", {15'd0, lo_cout}, 16'd1);
      chk("chain hi mout", {14'd0, hi_mout}, 16'd2);
      edge_settle();
      chk("chain up", {hi_fout, lo_fout}, 16'h0100);
      chk("chain lo tc", {15'd0, lo_tc}, 16'd1);
      chk("chain hi tc", {15'd0, hi_tc}, 16'd0);
      c_min = 2'b11;
      #1;
      chk("chain lo cout down", {15'd0, lo_cout}, 16'd1);
      chk("chain hi cout down", {15'd0, hi_cout}, 16'd0);
      edge_settle();
      chk("chain down", {hi_fout, lo_fout}, 16'h00FF);
`endif

      // Randomized run against the arithmetic model.
      rstn = 1'b0; min = 2'b00; cin = 1'b0;
      edge_settle();
      m_val = 0; m_tc = 1'b0;
      for (int n = 0; n < 400; n++) begin
         int  k;
         bit  exp_c;
         rstn = ($urandom_range(0, 24) != 0);
         min  = 2'($urandom_range(0, 3));
         cin  = ($urandom_range(0, 3) != 0);
         k    = $urandom_range(0, 3);
         pin  = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom);
         exp_c = !saturate && cin &&
                 ((min == 2'b10 && m_val == 255) || (min == 2'b11 && m_val == 0));
         #1;
         chk($sformatf("r%0d cout", n), {15'd0, cout}, {15'd0, exp_c});
         chk($sformatf("r%0d mout", n), {14'd0, mout}, {14'd0, min});
         if (!rstn) begin
            m_val = 0; m_tc = 1'b0;
         end else begin
            m_tc = 1'b0;
            if (min == 2'b01) m_val = int'(pin);
            else if (min == 2'b10 && cin) begin
               if (m_val == 255) begin
                  m_tc = 1'b1;
                  m_val = saturate ? 255 : 0;
               end else m_val = m_val + 1;
            end else if (min == 2'b11 && cin) begin
               if (m_val == 0) begin
                  m_tc = 1'b1;
                  m_val = saturate ? 0 : 255;
               end else m_val = m_val - 1;
            end
         end
         edge_settle();
         chk($sformatf("r%0d fout", n), {8'd0, fout}, 16'(m_val));
         chk($sformatf("r%0d tc", n), {15'd0, tc}, {15'd0, m_tc});
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
